ula_mdu_sequencer: RTL
======================

// Module: ula_mdu_sequencer
// PURPOSE
//  Multi-cycle M-extension sequencer: computes MUL (low XLEN bits), DIVU and REMU by driving the
//  datapath's shared ula (s1/s2/sub -> res) one add or subtract per cycle.
//  Sits beside the execute stage. The ula is instantiated by the parent; this block owns its inputs
//  while busy. Valid/ready handshake on both request and response sides.
// PARAMETERS
//  XLEN   64   operand/result width; must match the ula width
//  CNT_W  7    iteration counter width, >= clog2(XLEN)+1
// PORTS
//  clk        in   1     clock, rising edge
//  rst_n      in   1     asynchronous, active-low reset
//  req_valid  in   1     request present
//  req_ready  out  1     block can accept (state==IDLE)
//  req_op     in   2     00 MUL, 01 DIVU, 10 REMU, 11 reserved
//  req_a      in   XLEN  multiplicand / dividend
//  req_b      in   XLEN  multiplier / divisor
//  resp_valid out  1     result available, held until taken
//  resp_ready in   1     consumer takes result
//  resp_data  out  XLEN  result
//  ula_s1     out  XLEN  to ula.s1
//  ula_s2     out  XLEN  to ula.s2
//  ula_sub    out  1     to ula.sub
//  ula_res    in   XLEN  from ula.res (combinational, same cycle)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, req_ready=1, resp_valid=0, resp_data=0, ula_s1=ula_s2=0,
//    ula_sub=0. All datapath regs cleared. A request in flight when reset asserts is dropped, no response.
//  States: IDLE -> MUL | DIV | DONE; MUL -> DONE; DIV -> DONE; DONE -> IDLE.
//  Accept: req_valid&req_ready in cycle T latches op/a/b; busy from T+1. Inputs ignored outside IDLE.
//  MUL: acc=0, mcand=a, mplier=b. Each iter: ula_s1=acc, ula_s2=mcand, sub=0.
//    If mplier[0], acc<=ula_res. Then mcand<<=1, mplier>>=1. XLEN iters (T+1..T+XLEN).
//    resp_valid=1 at T+XLEN+1. Overflow bits discarded (mod 2^XLEN).
//  DIVU/REMU (b!=0): restoring. rem=0, quo=a. Each iter: {carry,shr} = {rem,quo[XLEN-1]};
//    ula_s1=shr, ula_s2=b, sub=1. take = carry | (shr >= b), local unsigned compare.
//    rem <= take ? ula_res : shr. quo <= {quo[XLEN-2:0], take}.
//    XLEN iters; resp_data = quo (DIVU) or rem (REMU). Same latency as MUL.
//  b==0 on DIVU/REMU: no iteration, IDLE->DONE. resp_valid at T+1.
//    DIVU returns all ones; REMU returns a (RISC-V spec).
//  op 11: IDLE->DONE, resp_data=0, resp_valid at T+1.
//  Outside MUL/DIV states: ula_s1=ula_s2=0, ula_sub=0. Parent may mux the ula to other users when
//    req_ready|resp_valid.
//  DONE: resp_valid=1, resp_data stable until resp_ready. Transfer cycle -> IDLE.
//    req_ready=1 the next cycle; no same-cycle accept, so the minimum back-to-back gap is one cycle.
//  Counter counts XLEN-1 down to 0; exit on 0. No early termination.
// STRUCTURE
//  Shared include ula_mdu_defs.vh: op codes (MDU_MUL/DIVU/REMU), state encodings, XLEN default.
//  No sub-module: the ula is external; counter and comparator are inline.
//  Parent instantiates ula and ula_mdu_sequencer and connects ula_* ports.
// TESTING
//  Reset mid-DIV (rst_n low at iteration 20) -> req_ready=1, resp_valid=0, ula_* = 0 immediately.
//  MUL a=7, b=6 -> resp_data=42 at T+65; a=2^63, b=2 -> 0.
//    Also MUL a=all ones, b=all ones -> 1.
//  DIVU a=100, b=7 -> 14; REMU -> 2; both resp_valid at T+65.
//    DIVU a=all ones, b=2^63 -> 1, exercises the carry path.
//  DIVU a=5, b=0 -> 0xFFFF_FFFF_FFFF_FFFF; REMU a=5, b=0 -> 5; resp_valid at T+1.
//  Backpressure: hold resp_ready=0 for 10 cycles -> resp_data stable, req_ready=0, new req_valid ignored.
//  Random: 2000 ops vs a*b, a/b, a%b reference model, random resp_ready, req_valid held across busy.

Source files
------------

// File: rtl/ula_mdu_sequencer_pkg.sv
// Shared definitions for the M-extension sequencer: op codes, FSM states and width defaults.
package ula_mdu_sequencer_pkg;

  localparam int MDU_XLEN  = 64;
  localparam int MDU_CNT_W = 7;

  typedef enum logic [1:0] {
    MDU_MUL  = 2'b00,
    MDU_DIVU = 2'b01,
    MDU_REMU = 2'b10,
    MDU_RSVD = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } mdu_state_e;

  // RISC-V defines division by zero: quotient is all ones, remainder is the dividend.
  function automatic logic [MDU_XLEN-1:0] div_by_zero_result(mdu_op_e op, logic [MDU_XLEN-1:0] a);
    return (op == MDU_DIVU) ? '1 : a;
  endfunction

endpackage

// File: rtl/ula_mdu_sequencer_if.sv
// Request/response valid-ready bus between the execute stage and the MDU sequencer.
interface ula_mdu_sequencer_if
  import ula_mdu_sequencer_pkg::*;
#(
  parameter int XLEN = MDU_XLEN
);

  logic            req_valid;
  logic            req_ready;
  logic [1:0]      req_op;
  logic [XLEN-1:0] req_a;
  logic [XLEN-1:0] req_b;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_data;

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_data
  );

endinterface

// File: rtl/ula_mdu_sequencer.sv
// Multi-cycle MUL/DIVU/REMU sequencer that drives the shared ula one add or subtract per cycle.
// acc_q/a_q/b_q hold acc/mcand/mplier for MUL and rem/quo/divisor for DIVU/REMU.
module ula_mdu_sequencer
  import ula_mdu_sequencer_pkg::*;
#(
  parameter int XLEN  = MDU_XLEN,
  parameter int CNT_W = MDU_CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  ula_mdu_sequencer_if.slave  bus,
  output logic [XLEN-1:0]     ula_s1,
  output logic [XLEN-1:0]     ula_s2,
  output logic                ula_sub,
  input  logic [XLEN-1:0]     ula_res
);

  mdu_state_e       state_q;
  mdu_op_e          op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  acc_q, a_q, b_q;
  logic [XLEN-1:0]  acc_nxt, a_nxt, b_nxt;
  logic [XLEN-1:0]  shr;
  logic             take;
  logic             req_ready_q, resp_valid_q;
  logic [XLEN-1:0]  resp_data_q;
  mdu_op_e          req_op;

  assign req_op         = mdu_op_e'(bus.req_op);
  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;

  // Restoring-division step: a carry out of the shifted remainder always means it exceeds b.
  assign shr  = {acc_q[XLEN-2:0], a_q[XLEN-1]};
  assign take = acc_q[XLEN-1] | (shr >= b_q);

  // The ula is only driven while iterating, so the parent can reuse it otherwise.
  always_comb begin
    ula_s1  = '0;
    ula_s2  = '0;
    ula_sub = 1'b0;
    case (state_q)
      ST_MUL: begin
        ula_s1 = acc_q;
        ula_s2 = a_q;
      end
      ST_DIV: begin
        ula_s1  = shr;
        ula_s2  = b_q;
        ula_sub = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    acc_nxt = acc_q;
    a_nxt   = a_q;
    b_nxt   = b_q;
    case (state_q)
      ST_MUL: begin
        if (b_q[0]) acc_nxt = ula_res;
        a_nxt = a_q << 1;
        b_nxt = b_q >> 1;
      end
      ST_DIV: begin
        acc_nxt = take ? ula_res : shr;
        a_nxt   = {a_q[XLEN-2:0], take};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      op_q         <= MDU_MUL;
      cnt_q        <= '0;
      acc_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            op_q        <= req_op;
            cnt_q       <= CNT_W'(XLEN - 1);
            acc_q       <= '0;
            a_q         <= bus.req_a;
            b_q         <= bus.req_b;
            req_ready_q <= 1'b0;
            case (req_op)
              MDU_MUL: state_q <= ST_MUL;
              MDU_DIVU, MDU_REMU: begin
                if (bus.req_b == '0) begin
                  resp_data_q  <= div_by_zero_result(req_op, bus.req_a);
                  resp_valid_q <= 1'b1;
                  state_q      <= ST_DONE;
                end else begin
                  state_q <= ST_DIV;
                end
              end
              default: begin
                resp_data_q  <= '0;
                resp_valid_q <= 1'b1;
                state_q      <= ST_DONE;
              end
            endcase
          end
        end
        ST_MUL, ST_DIV: begin
          acc_q <= acc_nxt;
          a_q   <= a_nxt;
          b_q   <= b_nxt;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            if (state_q == ST_MUL)       resp_data_q <= acc_nxt;
            else if (op_q == MDU_REMU)   resp_data_q <= acc_nxt;
            else                         resp_data_q <= a_nxt;
            resp_valid_q <= 1'b1;
            state_q      <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
